// File: rtl/shift_right_unit_pkg.sv
// shift_right_unit_pkg: shared state encodings and fill-mode constants for the right-shift unit
package shift_right_unit_pkg;

    typedef enum logic [1:0] {
        SR_IDLE  = 2'd0,
        SR_SHIFT = 2'd1,
        SR_DONE  = 2'd2
    } sr_state_e;

    localparam logic FILL_ZERO = 1'b0;
    localparam logic FILL_SIGN = 1'b1;

endpackage

// File: rtl/shift_right_one.sv
// shift_right_one: single-position right shift with a caller-supplied fill bit
module shift_right_one #(
    parameter int N = 32
) (
    input  logic [N-1:0] In,
    input  logic         fill,
    output logic [N-1:0] out
);

    assign out = {fill, In[N-1:1]};

endmodule

// File: rtl/shift_right_unit.sv
// shift_right_unit: sequential SRL/SRA unit shifting one bit per clock with start/busy/done handshake
module shift_right_unit
    import shift_right_unit_pkg::*;
#(
    parameter int N   = 32,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           arith,
    input  logic [N-1:0]   In,
    input  logic [SHW-1:0] shamt,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   out
);

    sr_state_e      state_q, state_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [N-1:0]   wr_q, wr_d;
    logic [N-1:0]   out_q, out_d;
    logic           fill_mode_q, fill_mode_d;
    logic           done_q, done_d;
    logic [N-1:0]   wr_step;

    // the sign bit is re-read from the working register each step, so it is the latched MSB
    shift_right_one #(.N(N)) u_step (
        .In   (wr_q),
        .fill ((fill_mode_q == FILL_SIGN) ? wr_q[N-1] : FILL_ZERO),
        .out  (wr_step)
    );

    // next-state, datapath and handshake decode; start only matters in IDLE
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        out_d       = out_q;
        fill_mode_d = fill_mode_q;
        done_d      = 1'b0;
        case (state_q)
            SR_IDLE: begin
                if (start) begin
                    wr_d        = In;
                    cnt_d       = shamt;
                    fill_mode_d = arith;
                    state_d     = (shamt == '0) ? SR_DONE : SR_SHIFT;
                end
            end
            SR_SHIFT: begin
                wr_d    = wr_step;
                cnt_d   = cnt_q - SHW'(1);
                state_d = (cnt_q == SHW'(1)) ? SR_DONE : SR_SHIFT;
            end
            SR_DONE: begin
                out_d   = wr_q;
                done_d  = 1'b1;
                state_d = SR_IDLE;
            end
            default: state_d = SR_IDLE;
        endcase
    end

    // state registers with asynchronous clear that discards any in-flight operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SR_IDLE;
            cnt_q       <= '0;
            wr_q        <= '0;
            out_q       <= '0;
            fill_mode_q <= FILL_ZERO;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            out_q       <= out_d;
            fill_mode_q <= fill_mode_d;
            done_q      <= done_d;
        end
    end

    assign busy = (state_q != SR_IDLE);
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_shift_right_unit.sv
// tb_shift_right_unit: randomized scoreboard bench for shift_right_unit against an arithmetic shift model
module tb_shift_right_unit;

    logic        clk, rst, start, arith, busy, done;
    logic [31:0] In, out;
    logic [4:0]  shamt;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        int          when;
    } exp_t;

    exp_t sb[$];

    shift_right_unit #(.N(32), .SHW(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .arith (arith),
        .In    (In),
        .shamt (shamt),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(logic [31:0] v, int sh, logic ar);
        logic signed [31:0] s;
        s = v;
        return ar ? 32'(s >>> sh) : (v >> sh);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", out, e.res);
                chk("latency", 32'(cyc), 32'(e.when));
            end
        end
    end

    task automatic issue(logic [31:0] v, int sh, logic ar, bit noisy);
        exp_t e;
        int k, bcnt;
        @(negedge clk);
        start = 1; In = v; shamt = 5'(sh); arith = ar;
        @(posedge clk);
        #1 k = cyc;
        e.res = model(v, sh, ar);
        e.when = k + sh + 1;
        sb.push_back(e);
        bcnt = 0;
        for (int i = 0; i <= sh; i++) begin
            @(negedge clk);
            if (busy === 1'b1) bcnt++;
            if (noisy) begin
                start = 1'($urandom); In = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
            end else start = 0;
        end
        @(negedge clk);
        start = 0;
        chk("busy_cycles", 32'(bcnt), 32'(sh + 1));
        chk("busy_low_at_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; start = 0; arith = 0; In = '0; shamt = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_out", out, 32'd0);
        rst = 0;
        @(negedge clk);
        issue(32'h8000_0000, 31, 0, 0);
        issue(32'h8000_0000, 4, 1, 0);
        issue(32'h7000_0000, 4, 1, 0);
        issue(32'hDEAD_BEEF, 0, 0, 0);
        issue(32'hDEAD_BEEF, 0, 1, 0);
        issue(32'h8765_4321, 13, 1, 1);
        issue(32'h8765_4321, 13, 0, 1);
        issue(32'hF000_000F, 1, 1, 1);
        issue(32'hF000_000F, 0, 1, 1);
        // mid-operation reset: discard a shamt=10 op at its third cycle
        @(negedge clk);
        start = 1; In = 32'hFFFF_0000; shamt = 5'd10; arith = 1;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        #2 rst = 1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_out", out, 32'd0);
        @(negedge clk);
        rst = 0;
        repeat (15) @(negedge clk);
        chk("midrst_idle", {31'd0, busy}, 32'd0);
        issue(32'h1234_5678, 10, 0, 0);
        for (int t = 0; t < 25; t++) begin
            int sh;
            sh = (t % 5 == 0) ? 31 : int'($urandom_range(0, 31));
            issue($urandom, sh, 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int w = 0; w < 100 && sb.size() != 0; w++) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
